// File: rtl/mem_bus_bridge_pkg.sv
// Shared types and helpers for the memory bus bridge.
// Op/fault encodings, FSM states, lane-select and store-replication helpers.
package mem_pkg;

  typedef enum logic [1:0] {
    BYTE    = 2'b00,
    HALF    = 2'b01,
    WORD    = 2'b10,
    ILLEGAL = 2'b11
  } mem_op_e;

  typedef enum logic [1:0] {
    OK      = 2'b00,
    ALIGN   = 2'b01,
    BUS_ERR = 2'b10,
    TIMEOUT = 2'b11
  } mem_fault_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BUS  = 2'b01,
    S_RESP = 2'b10
  } bridge_state_e;

  localparam int DEFAULT_TIMEOUT = 255;

  function automatic logic op_illegal(
    input mem_op_e    op,
    input logic [1:0] a
  );
    logic r;
    unique case (op)
      BYTE:    r = 1'b0;
      HALF:    r = a[0];
      WORD:    r = (a != 2'b00);
      default: r = 1'b1;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] lane_sel(
    input mem_op_e    op,
    input logic [1:0] a
  );
    logic [3:0] s;
    unique case (op)
      BYTE:    s = 4'b0001 << a;
      HALF:    s = a[1] ? 4'b1100 : 4'b0011;
      default: s = 4'b1111;
    endcase
    return s;
  endfunction

  function automatic logic [31:0] lane_wdata(
    input mem_op_e     op,
    input logic [31:0] d
  );
    logic [31:0] w;
    unique case (op)
      BYTE:    w = {4{d[7:0]}};
      HALF:    w = {2{d[15:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/mem_bus_bridge_lane_extract.sv
// Combinational read-lane select with sign/zero extension.
// Ports: op/is_unsigned/addr_lo select the lane, rdata in, data out.
module mem_lane_extract
  import mem_pkg::*;
(
  input  logic [1:0]  op,
  input  logic        is_unsigned,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rdata,
  output logic [31:0] data
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = rdata[8*addr_lo +: 8];
    h = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    unique case (mem_op_e'(op))
      BYTE:    data = {{24{b[7] & ~is_unsigned}}, b};
      HALF:    data = {{16{h[15] & ~is_unsigned}}, h};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_bus_bridge.sv
// Load/store request to single-beat bus bridge with fault reporting.
// Ports: req_* handshake in, resp_* pulse out, bus_* master side.
// Optional abort of stuck bus cycles when MEM_BUS_TIMEOUT_EN is defined.
module mem_bus_bridge
  import mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic        req_unsigned,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic [1:0]  resp_fault,
  output logic        bus_cyc,
  output logic        bus_we,
  output logic [29:0] bus_addr,
  output logic [3:0]  bus_sel,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic        bus_err,
  input  logic [31:0] bus_rdata
);

  bridge_state_e state;
  mem_op_e       op_in;
  logic [1:0]    lat_op;
  logic          lat_uns;
  logic [1:0]    lat_lo;
  logic [31:0]   ext_data;

  assign op_in = mem_op_e'(req_op);

  // Gated by reset so nothing is accepted while reset is held.
  assign req_ready = (state == S_IDLE) & req_valid & ~reset;

  mem_lane_extract u_extract (
    .op          (lat_op),
    .is_unsigned (lat_uns),
    .addr_lo     (lat_lo),
    .rdata       (bus_rdata),
    .data        (ext_data)
  );

`ifdef MEM_BUS_TIMEOUT_EN
  localparam int TCW =
    (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [TCW-1:0] TMO_LAST = TCW'(TIMEOUT_CYCLES - 1);
  logic [TCW-1:0] tmo_cnt;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_fault <= OK;
      bus_cyc    <= 1'b0;
      bus_we     <= 1'b0;
      bus_addr   <= '0;
      bus_sel    <= '0;
      bus_wdata  <= '0;
      lat_op     <= '0;
      lat_uns    <= 1'b0;
      lat_lo     <= '0;
`ifdef MEM_BUS_TIMEOUT_EN
      tmo_cnt    <= '0;
`endif
    end else begin
      resp_valid <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (req_valid) begin
            if (op_illegal(op_in, req_addr[1:0])) begin
              state      <= S_RESP;
              resp_valid <= 1'b1;
              resp_fault <= ALIGN;
              resp_rdata <= '0;
            end else begin
              state     <= S_BUS;
              bus_cyc   <= 1'b1;
              bus_we    <= req_write;
              bus_addr  <= req_addr[31:2];
              bus_sel   <= lane_sel(op_in, req_addr[1:0]);
              bus_wdata <= lane_wdata(op_in, req_wdata);
              lat_op    <= req_op;
              lat_uns   <= req_unsigned;
              lat_lo    <= req_addr[1:0];
`ifdef MEM_BUS_TIMEOUT_EN
              tmo_cnt   <= '0;
`endif
            end
          end
        end
        S_BUS: begin
          // Error wins over a simultaneous ack.
          if (bus_err) begin
            state      <= S_RESP;
            resp_valid <= 1'b1;
            resp_fault <= BUS_ERR;
            resp_rdata <= '0;
            bus_cyc    <= 1'b0;
            bus_we     <= 1'b0;
          end else if (bus_ack) begin
            state      <= S_RESP;
            resp_valid <= 1'b1;
            resp_fault <= OK;
            resp_rdata <= bus_we ? 32'd0 : ext_data;
            bus_cyc    <= 1'b0;
            bus_we     <= 1'b0;
`ifdef MEM_BUS_TIMEOUT_EN
          end else if (tmo_cnt == TMO_LAST) begin
            state      <= S_RESP;
            resp_valid <= 1'b1;
            resp_fault <= TIMEOUT;
            resp_rdata <= '0;
            bus_cyc    <= 1'b0;
            bus_we     <= 1'b0;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
`endif
          end
        end
        S_RESP: begin
          state      <= S_IDLE;
          resp_rdata <= '0;
          resp_fault <= OK;
          bus_addr   <= '0;
          bus_sel    <= '0;
          bus_wdata  <= '0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_bridge.sv
// Directed and randomized checks of mem_bus_bridge against a
// behavioural model of lane selection, extension and latency.
module tb_mem_bus_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_write, req_unsigned;
  logic [1:0]  req_op;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready, resp_valid;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_fault;
  logic        bus_cyc, bus_we;
  logic [29:0] bus_addr;
  logic [3:0]  bus_sel;
  logic [31:0] bus_wdata;
  logic        bus_ack, bus_err;
  logic [31:0] bus_rdata;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  mem_bus_bridge #(.TIMEOUT_CYCLES(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_write    (req_write),
    .req_unsigned (req_unsigned),
    .req_op       (req_op),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_ready    (req_ready),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_fault   (resp_fault),
    .bus_cyc      (bus_cyc),
    .bus_we       (bus_we),
    .bus_addr     (bus_addr),
    .bus_sel      (bus_sel),
    .bus_wdata    (bus_wdata),
    .bus_ack      (bus_ack),
    .bus_err      (bus_err),
    .bus_rdata    (bus_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int nbytes(input logic [1:0] op);
    return (op == 2'd0) ? 1 : (op == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit m_illegal(input logic [1:0] op, input int a);
    if (op == 2'd3) return 1'b1;
    return (a % nbytes(op)) != 0;
  endfunction

  function automatic logic [31:0] m_sel(input logic [1:0] op, input int a);
    int n = nbytes(op);
    return 32'(((1 << n) - 1) << a);
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] op,
                                          input logic [31:0] d);
    if (op == 2'd0) return (d & 32'hFF) * 32'h0101_0101;
    if (op == 2'd1) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] rd,
                                         input logic [1:0] op, input int a,
                                         input bit uns);
    longint bits = 8 * nbytes(op);
    longint v = longint'(rd) >> (8 * a);
    longint span = longint'(1) << bits;
    v = v % span;
    if (!uns && bits < 32 && v >= span / 2) v = v - span;
    return v[31:0];
  endfunction

  // mode: 0 ack, 1 err, 2 ack+err, 3 never respond
  task automatic run_txn(input string tag, input bit w, input bit uns,
                         input logic [1:0] op, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] rd,
                         input int waits, input int mode);
    int a = int'(addr[1:0]);
    bit ill = m_illegal(op, a);
    logic [31:0] e_data;
    logic [31:0] e_fault;
    req_valid = 1'b1;
    req_write = w;
    req_unsigned = uns;
    req_op = op;
    req_addr = addr;
    req_wdata = wd;
    #1;
    chk({tag, ".ready"}, 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    req_wdata = $urandom;
    if (ill) begin
      e_fault = 32'd1;
      e_data = 32'd0;
    end else begin
      for (int i = 0; i <= waits; i++) begin
        chk({tag, ".cyc"}, 32'(bus_cyc), 32'd1);
        chk({tag, ".we"}, 32'(bus_we), 32'(w));
        chk({tag, ".addr"}, 32'(bus_addr), addr >> 2);
        chk({tag, ".sel"}, 32'(bus_sel), m_sel(op, a));
        chk({tag, ".wd"}, bus_wdata, m_wdata(op, wd));
        chk({tag, ".rv_busy"}, 32'(resp_valid), 32'd0);
        if (i == waits && mode != 3) begin
          bus_ack = (mode != 1);
          bus_err = (mode != 0);
          bus_rdata = rd;
        end else begin
          bus_rdata = $urandom;
        end
        tick();
        bus_ack = 1'b0;
        bus_err = 1'b0;
      end
      if (mode == 3) begin
        e_fault = 32'd3;
        e_data = 32'd0;
      end else if (mode != 0) begin
        e_fault = 32'd2;
        e_data = 32'd0;
      end else begin
        e_fault = 32'd0;
        e_data = w ? 32'd0 : m_load(rd, op, a, uns);
      end
    end
    chk({tag, ".rv"}, 32'(resp_valid), 32'd1);
    chk({tag, ".fault"}, 32'(resp_fault), e_fault);
    chk({tag, ".rdata"}, resp_rdata, e_data);
    chk({tag, ".cyc_off"}, 32'(bus_cyc), 32'd0);
    req_valid = 1'b1;
    #1;
    chk({tag, ".no_b2b"}, 32'(req_ready), 32'd0);
    req_valid = 1'b0;
    tick();
    chk({tag, ".rv_once"}, 32'(resp_valid), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_unsigned = 1'b0;
    req_op = 2'd0;
    req_addr = '0;
    req_wdata = '0;
    bus_ack = 1'b1;
    bus_err = 1'b0;
    bus_rdata = '0;
    tick();
    tick();
    chk("rst.ready", 32'(req_ready), 32'd0);
    chk("rst.rv", 32'(resp_valid), 32'd0);
    chk("rst.cyc", 32'(bus_cyc), 32'd0);
    chk("rst.sel", 32'(bus_sel), 32'd0);
    chk("rst.fault", 32'(resp_fault), 32'd0);
    req_valid = 1'b0;
    reset = 1'b0;
    tick();

    // Stray bus responses outside a bus cycle are ignored.
    bus_ack = 1'b1;
    bus_err = 1'b1;
    tick();
    bus_ack = 1'b0;
    bus_err = 1'b0;
    chk("stray.rv", 32'(resp_valid), 32'd0);
    chk("stray.cyc", 32'(bus_cyc), 32'd0);

    run_txn("lb_1003", 0, 0, 2'd0, 32'h1003, 32'h0, 32'h80FF_FFFF, 0, 0);
    run_txn("sh_2002", 1, 0, 2'd1, 32'h2002, 32'h0000_BEEF, 32'h0, 3, 0);
    run_txn("lw_3001", 0, 0, 2'd2, 32'h3001, 32'h0, 32'h0, 0, 0);
    run_txn("op11", 0, 0, 2'd3, 32'h3000, 32'h0, 32'h0, 0, 0);
    run_txn("sh_odd", 1, 1, 2'd1, 32'h4001, 32'h1234, 32'h0, 0, 0);
    run_txn("ack_err", 0, 1, 2'd2, 32'h5000, 32'h0, 32'hDEAD_BEEF, 1, 2);
    run_txn("err", 1, 0, 2'd0, 32'h6001, 32'hA5, 32'h0, 2, 1);
    run_txn("lhu", 0, 1, 2'd1, 32'h7002, 32'h0, 32'h8001_7FFF, 0, 0);

`ifdef MEM_BUS_TIMEOUT_EN
    run_txn("tmo", 0, 0, 2'd2, 32'h8000, 32'h0, 32'h0, 3, 3);
`else
    run_txn("long_wait", 0, 0, 2'd2, 32'h8000, 32'h0, 32'hCAFE_F00D, 20, 0);
`endif

    for (int n = 0; n < 60; n++) begin
      logic [31:0] addr = $urandom;
      logic [1:0] op = 2'($urandom_range(0, 3));
      int waits = $urandom_range(0, 3);
      int mode = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 2)) : 0;
      run_txn("rnd", 1'($urandom), 1'($urandom), op, addr, $urandom,
              $urandom, waits, mode);
    end

    // Reset while a bus cycle is outstanding discards the request.
    req_valid = 1'b1;
    req_write = 1'b0;
    req_op = 2'd2;
    req_addr = 32'h9000;
    tick();
    req_valid = 1'b0;
    chk("rbus.cyc", 32'(bus_cyc), 32'd1);
    reset = 1'b1;
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    chk("rbus.cyc_off", 32'(bus_cyc), 32'd0);
    chk("rbus.rv", 32'(resp_valid), 32'd0);
    reset = 1'b0;
    tick();
    chk("rbus.rv2", 32'(resp_valid), 32'd0);
    chk("rbus.cyc2", 32'(bus_cyc), 32'd0);
    tick();
    chk("rbus.rv3", 32'(resp_valid), 32'd0);
    run_txn("post_rst", 0, 0, 2'd0, 32'hA002, 32'h0, 32'h0055_0000, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
